issue_queue_ctrl: RTL and testbench



---
 rtl/issue_queue_ctrl_if.sv | 37 +++
 rtl/issue_queue_ctrl.sv | 106 ++++++++++
 tb/tb_issue_queue_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_ctrl_if.sv
// Dispatch, wakeup, pick and queue-state signals of the 4-entry issue queue.
// The slave modport is the queue controller. The master modport is its environment.
interface issue_queue_ctrl_if;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_src0_rob;
  logic [3:0]  disp_src1_rob;
  logic [3:0]  disp_dst_rob;
  logic        disp_src0_rdy;
  logic        disp_src1_rdy;
  logic        wb_valid;
  logic [3:0]  wb_rob;
  logic [3:0]  pick_en;
  logic        flush;
  logic [3:0]  q_valid;
  logic [15:0] q_src0_rob;
  logic [15:0] q_src1_rob;
  logic [15:0] q_dst_rob;
  logic [3:0]  q_src0_rdy;
  logic [3:0]  q_src1_rdy;
  logic [2:0]  q_count;
  logic [1:0]  q_oldest;

  modport master (
    output disp_valid, disp_src0_rob, disp_src1_rob, disp_dst_rob,
           disp_src0_rdy, disp_src1_rdy, wb_valid, wb_rob, pick_en, flush,
    input  disp_ready, q_valid, q_src0_rob, q_src1_rob, q_dst_rob,
           q_src0_rdy, q_src1_rdy, q_count, q_oldest
  );

  modport slave (
    input  disp_valid, disp_src0_rob, disp_src1_rob, disp_dst_rob,
           disp_src0_rdy, disp_src1_rdy, wb_valid, wb_rob, pick_en, flush,
    output disp_ready, q_valid, q_src0_rob, q_src1_rob, q_dst_rob,
           q_src0_rdy, q_src1_rdy, q_count, q_oldest
  );
endinterface

// File: rtl/issue_queue_ctrl.sv
// 4-entry issue queue controller. It allocates to the lowest free entry and wakes up operands on writeback.
// A 4x4 age matrix tracks entry order so the oldest occupied entry can be reported.
module issue_queue_ctrl (
  input logic               clk,
  input logic               reset,
  issue_queue_ctrl_if.slave bus
);
  logic [3:0]       valid_q, valid_d;
  logic [3:0][3:0]  src0_rob_q, src0_rob_d;
  logic [3:0][3:0]  src1_rob_q, src1_rob_d;
  logic [3:0][3:0]  dst_rob_q, dst_rob_d;
  logic [3:0]       src0_rdy_q, src0_rdy_d;
  logic [3:0]       src1_rdy_q, src1_rdy_d;
  // age_q[i][j] = 1 means entry i is older than entry j
  logic [3:0][3:0]  age_q, age_d;

  logic [2:0] count_c;
  logic       ready_c;
  logic       accept_c;
  logic [1:0] alloc_idx_c;
  logic [1:0] oldest_c;
  logic       oldest_found_c;

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < 4; i++) count_c = count_c + 3'(valid_q[i]);
    ready_c = (count_c != 3'd4);

    alloc_idx_c = '0;
    for (int unsigned i = 4; i > 0; i--)
      if (!valid_q[i-1]) alloc_idx_c = 2'(i - 1);

    oldest_c       = '0;
    oldest_found_c = 1'b0;
    for (int unsigned i = 0; i < 4; i++)
      if (!oldest_found_c && valid_q[i] &&
          ((age_q[i] | ~valid_q | (4'd1 << i)) == 4'hF)) begin
        oldest_c       = 2'(i);
        oldest_found_c = 1'b1;
      end
  end

  always_comb begin
    accept_c   = bus.disp_valid && ready_c && !bus.flush;
    valid_d    = valid_q;
    src0_rob_d = src0_rob_q;
    src1_rob_d = src1_rob_q;
    dst_rob_d  = dst_rob_q;
    src0_rdy_d = src0_rdy_q;
    src1_rdy_d = src1_rdy_q;
    age_d      = age_q;
    if (bus.flush) begin
      valid_d = '0;
    end else begin
      // Wakeup is applied only to entries that survive this cycle's pick.
      for (int unsigned i = 0; i < 4; i++)
        if (valid_q[i] && !bus.pick_en[i] && bus.wb_valid) begin
          if (src0_rob_q[i] == bus.wb_rob) src0_rdy_d[i] = 1'b1;
          if (src1_rob_q[i] == bus.wb_rob) src1_rdy_d[i] = 1'b1;
        end
      valid_d = valid_q & ~bus.pick_en;
      if (accept_c) begin
        valid_d[alloc_idx_c]    = 1'b1;
        src0_rob_d[alloc_idx_c] = bus.disp_src0_rob;
        src1_rob_d[alloc_idx_c] = bus.disp_src1_rob;
        dst_rob_d[alloc_idx_c]  = bus.disp_dst_rob;
        src0_rdy_d[alloc_idx_c] = bus.disp_src0_rdy ||
                                  (bus.wb_valid && bus.disp_src0_rob == bus.wb_rob);
        src1_rdy_d[alloc_idx_c] = bus.disp_src1_rdy ||
                                  (bus.wb_valid && bus.disp_src1_rob == bus.wb_rob);
        age_d[alloc_idx_c] = '0;
        for (int unsigned j = 0; j < 4; j++) age_d[j][alloc_idx_c] = valid_q[j];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      src0_rob_q <= '0;
      src1_rob_q <= '0;
      dst_rob_q  <= '0;
      src0_rdy_q <= '0;
      src1_rdy_q <= '0;
      age_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      src0_rob_q <= src0_rob_d;
      src1_rob_q <= src1_rob_d;
      dst_rob_q  <= dst_rob_d;
      src0_rdy_q <= src0_rdy_d;
      src1_rdy_q <= src1_rdy_d;
      age_q      <= age_d;
    end
  end

  assign bus.disp_ready = ready_c;
  assign bus.q_valid    = valid_q;
  assign bus.q_src0_rob = src0_rob_q;
  assign bus.q_src1_rob = src1_rob_q;
  assign bus.q_dst_rob  = dst_rob_q;
  assign bus.q_src0_rdy = src0_rdy_q;
  assign bus.q_src1_rdy = src1_rdy_q;
  assign bus.q_count    = count_c;
  assign bus.q_oldest   = oldest_c;
endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Testbench for issue_queue_ctrl. The model keeps the queue entries in arrays and their age order in a queue.
// The DUT outputs are compared against the model on every falling edge.
module tb_issue_queue_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  issue_queue_ctrl_if bus();

  issue_queue_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model state. m_order lists the occupied entry indices from oldest to youngest.
  bit   [3:0] m_valid;
  logic [3:0] m_s0 [4];
  logic [3:0] m_s1 [4];
  logic [3:0] m_d  [4];
  bit   [3:0] m_r0, m_r1;
  int         m_order[$];

  always @(posedge clk or posedge reset) begin
    int  free_idx;
    bit  acc;
    if (reset) begin
      m_valid = '0; m_r0 = '0; m_r1 = '0;
      for (int i = 0; i < 4; i++) begin m_s0[i] = '0; m_s1[i] = '0; m_d[i] = '0; end
      m_order.delete();
    end else if (bus.flush) begin
      m_valid = '0;
      m_order.delete();
    end else begin
      free_idx = -1;
      for (int i = 0; i < 4; i++) if (!m_valid[i] && free_idx < 0) free_idx = i;
      acc = bus.disp_valid && (m_order.size() < 4);
      for (int i = 0; i < 4; i++)
        if (bus.pick_en[i] && m_valid[i]) begin
          m_valid[i] = 1'b0;
          for (int k = 0; k < m_order.size(); k++)
            if (m_order[k] == i) begin m_order.delete(k); break; end
        end
      for (int i = 0; i < 4; i++)
        if (m_valid[i] && bus.wb_valid) begin
          if (m_s0[i] == bus.wb_rob) m_r0[i] = 1'b1;
          if (m_s1[i] == bus.wb_rob) m_r1[i] = 1'b1;
        end
      if (acc) begin
        m_valid[free_idx] = 1'b1;
        m_s0[free_idx] = bus.disp_src0_rob;
        m_s1[free_idx] = bus.disp_src1_rob;
        m_d[free_idx]  = bus.disp_dst_rob;
        m_r0[free_idx] = bus.disp_src0_rdy || (bus.wb_valid && bus.disp_src0_rob == bus.wb_rob);
        m_r1[free_idx] = bus.disp_src1_rdy || (bus.wb_valid && bus.disp_src1_rob == bus.wb_rob);
        m_order.push_back(free_idx);
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e_s0, e_s1, e_d;
    for (int i = 0; i < 4; i++) begin
      e_s0[4*i +: 4] = m_s0[i];
      e_s1[4*i +: 4] = m_s1[i];
      e_d[4*i +: 4]  = m_d[i];
    end
    chk("m_q_valid",    16'(bus.q_valid),    16'(m_valid));
    chk("m_q_src0_rob", bus.q_src0_rob,      e_s0);
    chk("m_q_src1_rob", bus.q_src1_rob,      e_s1);
    chk("m_q_dst_rob",  bus.q_dst_rob,       e_d);
    chk("m_q_src0_rdy", 16'(bus.q_src0_rdy), 16'(m_r0));
    chk("m_q_src1_rdy", 16'(bus.q_src1_rdy), 16'(m_r1));
    chk("m_q_count",    16'(bus.q_count),    16'(m_order.size()));
    chk("m_q_oldest",   16'(bus.q_oldest),   16'((m_order.size() != 0) ? m_order[0] : 0));
    chk("m_disp_ready", 16'(bus.disp_ready), 16'(m_order.size() != 4));
  end

  task automatic idle();
    bus.disp_valid = 1'b0; bus.disp_src0_rob = '0; bus.disp_src1_rob = '0;
    bus.disp_dst_rob = '0; bus.disp_src0_rdy = 1'b0; bus.disp_src1_rdy = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rob = '0; bus.pick_en = '0; bus.flush = 1'b0;
  endtask

  task automatic disp(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] d,
                      input logic r0, input logic r1);
    bus.disp_valid = 1'b1; bus.disp_src0_rob = s0; bus.disp_src1_rob = s1;
    bus.disp_dst_rob = d; bus.disp_src0_rdy = r0; bus.disp_src1_rdy = r1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 16'(bus.q_valid), 16'h0);
    chk("rst_count", 16'(bus.q_count), 16'h0);
    chk("rst_ready", 16'(bus.disp_ready), 16'h1);
    chk("rst_oldest", 16'(bus.q_oldest), 16'h0);
    reset = 1'b0;
    step();

    // Fill the queue. Entry 2 gets src0 tag 5.
    for (int i = 0; i < 4; i++) begin
      idle();
      disp((i == 2) ? 4'd5 : 4'(8 + i), 4'(9 + i), 4'(i + 1), 1'b0, 1'b0);
      step();
    end
    idle();
    chk("fill_valid", 16'(bus.q_valid), 16'hF);
    chk("fill_count", 16'(bus.q_count), 16'h4);
    chk("fill_ready", 16'(bus.disp_ready), 16'h0);
    chk("fill_oldest", 16'(bus.q_oldest), 16'h0);
    chk("fill_dst", bus.q_dst_rob, 16'h4321);
    disp(4'd0, 4'd0, 4'd6, 1'b0, 1'b0);
    step();
    idle();
    chk("full_ignore_valid", 16'(bus.q_valid), 16'hF);
    chk("full_ignore_dst", bus.q_dst_rob, 16'h4321);

    // Wakeup tag 5
    bus.wb_valid = 1'b1; bus.wb_rob = 4'd5;
    step();
    idle();
    chk("wake_src0_rdy", 16'(bus.q_src0_rdy), 16'h4);
    chk("wake_src1_rdy", 16'(bus.q_src1_rdy), 16'h0);

    // Pick entry 0, then reuse it with a same-cycle bypass on src1
    bus.pick_en = 4'b0001;
    step();
    idle();
    chk("pick_valid", 16'(bus.q_valid), 16'hE);
    chk("pick_oldest", 16'(bus.q_oldest), 16'h1);
    chk("pick_count", 16'(bus.q_count), 16'h3);
    disp(4'd3, 4'd7, 4'd5, 1'b0, 1'b0);
    bus.wb_valid = 1'b1; bus.wb_rob = 4'd7;
    step();
    idle();
    chk("reuse_valid", 16'(bus.q_valid), 16'hF);
    chk("reuse_oldest", 16'(bus.q_oldest), 16'h1);
    chk("bypass_src1_rdy", 16'(bus.q_src1_rdy), 16'h1);
    chk("bypass_src0_rdy", 16'(bus.q_src0_rdy), 16'h4);

    // A dispatch while the queue is full waits, even if an entry is picked in the same cycle.
    bus.pick_en = 4'b0100;
    disp(4'd1, 4'd2, 4'd13, 1'b0, 1'b0);
    step();
    chk("fullpick_valid", 16'(bus.q_valid), 16'hB);
    chk("fullpick_dst", bus.q_dst_rob, 16'h4325);
    bus.pick_en = '0;
    step();
    idle();
    chk("fullpick_next_valid", 16'(bus.q_valid), 16'hF);
    chk("fullpick_next_dst", bus.q_dst_rob, 16'h4D25);
    chk("fullpick_next_oldest", 16'(bus.q_oldest), 16'h1);
    chk("fullpick_next_src0_rdy", 16'(bus.q_src0_rdy), 16'h0);

    // Flush has priority over dispatch and pick
    bus.flush = 1'b1; bus.pick_en = 4'b0010;
    disp(4'd1, 4'd1, 4'd1, 1'b1, 1'b1);
    step();
    idle();
    chk("flush_valid", 16'(bus.q_valid), 16'h0);
    chk("flush_count", 16'(bus.q_count), 16'h0);
    chk("flush_ready", 16'(bus.disp_ready), 16'h1);

    // Asynchronous reset partway through a fill
    disp(4'd2, 4'd3, 4'd4, 1'b1, 1'b1);
    step();
    step();
    chk("midfill_count", 16'(bus.q_count), 16'h2);
    reset = 1'b1;
    #1;
    chk("async_valid", 16'(bus.q_valid), 16'h0);
    chk("async_count", 16'(bus.q_count), 16'h0);
    chk("async_ready", 16'(bus.disp_ready), 16'h1);
    chk("async_dst", bus.q_dst_rob, 16'h0);
    chk("async_src0_rob", bus.q_src0_rob, 16'h0);
    chk("async_rdy", 16'({bus.q_src0_rdy, bus.q_src1_rdy}), 16'h0);
    chk("async_oldest", 16'(bus.q_oldest), 16'h0);
    idle();
    reset = 1'b0;
    step();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bus.disp_valid    = ($urandom_range(0, 3) != 0);
      bus.disp_src0_rob = 4'($urandom);
      bus.disp_src1_rob = 4'($urandom);
      bus.disp_dst_rob  = 4'($urandom);
      bus.disp_src0_rdy = ($urandom_range(0, 3) == 0);
      bus.disp_src1_rdy = ($urandom_range(0, 3) == 0);
      bus.wb_valid      = ($urandom_range(0, 1) == 0);
      bus.wb_rob        = 4'($urandom);
      bus.pick_en       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      bus.flush         = ($urandom_range(0, 40) == 0);
      if (n == 300) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      step();
    end
    idle();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
